// File: rtl/arp_req_arb_if.sv
// arp_req_arb_if: upstream per-port request/response lanes plus the shared downstream ARP lookup channel.
interface arp_req_arb_if #(parameter int PORTS = 2);
  logic [PORTS-1:0]    s_arp_request_valid;
  logic [PORTS-1:0]    s_arp_request_ready;
  logic [PORTS*32-1:0] s_arp_request_ip;
  logic [PORTS-1:0]    s_arp_response_valid;
  logic [PORTS-1:0]    s_arp_response_ready;
  logic [PORTS-1:0]    s_arp_response_error;
  logic [PORTS*48-1:0] s_arp_response_mac;
  logic                m_arp_request_valid;
  logic                m_arp_request_ready;
  logic [31:0]         m_arp_request_ip;
  logic                m_arp_response_valid;
  logic                m_arp_response_ready;
  logic                m_arp_response_error;
  logic [47:0]         m_arp_response_mac;
  modport slave (
    input  s_arp_request_valid, s_arp_request_ip, s_arp_response_ready,
           m_arp_request_ready, m_arp_response_valid, m_arp_response_error, m_arp_response_mac,
    output s_arp_request_ready, s_arp_response_valid, s_arp_response_error, s_arp_response_mac,
           m_arp_request_valid, m_arp_request_ip, m_arp_response_ready
  );
  modport master (
    output s_arp_request_valid, s_arp_request_ip, s_arp_response_ready,
           m_arp_request_ready, m_arp_response_valid, m_arp_response_error, m_arp_response_mac,
    input  s_arp_request_ready, s_arp_response_valid, s_arp_response_error, s_arp_response_mac,
           m_arp_request_valid, m_arp_request_ip, m_arp_response_ready
  );
endinterface

// File: rtl/arp_req_arb.sv
// arp_req_arb: shares one ARP lookup channel among PORTS requesters, one outstanding lookup at a time.
module arp_req_arb #(
  parameter int PORTS = 2,
  parameter int ARB_ROUND_ROBIN = 1,
  parameter int CL_PORTS = (PORTS > 1) ? $clog2(PORTS) : 1
) (
  input  logic                clk,
  input  logic                rst,
  arp_req_arb_if.slave        bus,
  output logic                busy,
  output logic [CL_PORTS-1:0] grant_index
);
  typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;
  state_t state, next_state;
  logic [CL_PORTS-1:0] ptr, win;
  logic any;
  logic [31:0] req_ip;
  always_comb begin
    win = '0;
    any = 1'b0;
    for (int k = PORTS - 1; k >= 0; k--) begin
      if (bus.s_arp_request_valid[ARB_ROUND_ROBIN != 0 ? (int'(ptr) + 1 + k) % PORTS : k]) begin
        win = CL_PORTS'(ARB_ROUND_ROBIN != 0 ? (int'(ptr) + 1 + k) % PORTS : k);
        any = 1'b1;
      end
    end
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= next_state;
  always_comb
    next_state = (state == IDLE && any) ? REQ :
                 (state == REQ && bus.m_arp_request_ready) ? RESP :
                 (state == RESP && bus.m_arp_response_valid && bus.m_arp_response_ready) ? IDLE : state;
  // Pointer moves only on completed responses, so an abandoned lookup never shifts fairness.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      grant_index <= '0;
      req_ip <= '0;
      ptr <= CL_PORTS'(PORTS - 1);
    end else begin
      if (state == IDLE && any) begin
        grant_index <= win;
        req_ip <= bus.s_arp_request_ip[int'(win)*32 +: 32];
      end
      if (state == RESP && bus.m_arp_response_valid && bus.m_arp_response_ready) ptr <= grant_index;
    end
  end
  always_comb begin
    busy = state != IDLE;
    bus.s_arp_request_ready = (state == IDLE && any) ? PORTS'(1) << win : '0;
    bus.m_arp_request_valid = state == REQ;
    bus.m_arp_request_ip = req_ip;
    bus.s_arp_response_valid = (state == RESP) ? PORTS'(bus.m_arp_response_valid) << grant_index : '0;
    bus.m_arp_response_ready = state == RESP && bus.s_arp_response_ready[grant_index];
    bus.s_arp_response_error = {PORTS{bus.m_arp_response_error}};
    bus.s_arp_response_mac = {PORTS{bus.m_arp_response_mac}};
  end
endmodule

// File: tb/tb_arp_req_arb.sv
// tb_arp_req_arb: directed checks of arbitration order, routing, backpressure and async reset.
module tb_arp_req_arb;
  logic clk, rst;
  logic a_busy, b_busy, c_busy;
  logic a_gnt, b_gnt;
  logic [1:0] c_gnt;
  int total, bad;
  arp_req_arb_if #(.PORTS(2)) ia ();
  arp_req_arb_if #(.PORTS(2)) ib ();
  arp_req_arb_if #(.PORTS(4)) ic ();
  arp_req_arb #(.PORTS(2), .ARB_ROUND_ROBIN(1)) u_a (.clk(clk), .rst(rst), .bus(ia), .busy(a_busy), .grant_index(a_gnt));
  arp_req_arb #(.PORTS(2), .ARB_ROUND_ROBIN(0)) u_b (.clk(clk), .rst(rst), .bus(ib), .busy(b_busy), .grant_index(b_gnt));
  arp_req_arb #(.PORTS(4), .ARB_ROUND_ROBIN(1)) u_c (.clk(clk), .rst(rst), .bus(ic), .busy(c_busy), .grant_index(c_gnt));
  initial clk = 0;
  always #5 clk = ~clk;
  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic a_lookup(input int p, input logic [31:0] ip, input logic [47:0] mac, input logic err,
                          input int rqw, input int rsd, input int rsw);
    logic [1:0] oh;
    oh = 2'b01 << p;
    ia.s_arp_request_valid = oh;
    ia.s_arp_request_ip[p*32 +: 32] = ip;
    #1 chk("accept", ia.s_arp_request_ready, oh);
    @(posedge clk); #2;
    ia.s_arp_request_valid = 0;
    chk("req_valid", ia.m_arp_request_valid, 1);
    chk("req_ip", ia.m_arp_request_ip, ip);
    chk("grant", a_gnt, p);
    chk("busy_req", a_busy, 1);
    chk("acc_once", ia.s_arp_request_ready, 0);
    repeat (rqw) begin
      @(posedge clk); #2;
      chk("hold_valid", ia.m_arp_request_valid, 1);
      chk("hold_ip", ia.m_arp_request_ip, ip);
    end
    ia.m_arp_request_ready = 1;
    @(posedge clk); #2;
    ia.m_arp_request_ready = 0;
    chk("req_done", ia.m_arp_request_valid, 0);
    repeat (rsd) begin
      chk("no_rsp", ia.s_arp_response_valid, 0);
      @(posedge clk); #2;
    end
    ia.m_arp_response_valid = 1;
    ia.m_arp_response_mac = mac;
    ia.m_arp_response_error = err;
    ia.s_arp_response_ready = ~oh;
    repeat (rsw) begin
      #1 chk("bp_ready", ia.m_arp_response_ready, 0);
      chk("bp_valid", ia.s_arp_response_valid, oh);
      @(posedge clk); #1;
    end
    ia.s_arp_response_ready = oh;
    #1 chk("rsp_valid", ia.s_arp_response_valid, oh);
    chk("rsp_ready", ia.m_arp_response_ready, 1);
    chk("rsp_err", ia.s_arp_response_error[p], err);
    chk("rsp_mac", ia.s_arp_response_mac[p*48 +: 48], mac);
    @(posedge clk); #2;
    ia.m_arp_response_valid = 0;
    ia.s_arp_response_ready = 0;
    chk("idle_after", a_busy, 0);
  endtask
  task automatic c_lookup(input logic [3:0] vm, input logic [3:0] exp);
    ic.s_arp_request_valid = vm;
    #1 chk("c_accept", ic.s_arp_request_ready, exp);
    @(posedge clk); #2;
    ic.s_arp_request_valid = 0;
    ic.m_arp_request_ready = 1;
    @(posedge clk); #2;
    ic.m_arp_request_ready = 0;
    ic.m_arp_response_valid = 1;
    ic.s_arp_response_ready = 4'hF;
    #1 chk("c_rsp_valid", ic.s_arp_response_valid, exp);
    @(posedge clk); #2;
    ic.m_arp_response_valid = 0;
    ic.s_arp_response_ready = 0;
    chk("c_idle", c_busy, 0);
  endtask
  initial begin
    int n;
    total = 0;
    bad = 0;
    rst = 1;
    {ia.s_arp_request_valid, ia.s_arp_request_ip, ia.s_arp_response_ready, ia.m_arp_request_ready,
     ia.m_arp_response_valid, ia.m_arp_response_error, ia.m_arp_response_mac} = '0;
    {ib.s_arp_request_valid, ib.s_arp_request_ip, ib.s_arp_response_ready, ib.m_arp_request_ready,
     ib.m_arp_response_valid, ib.m_arp_response_error, ib.m_arp_response_mac} = '0;
    {ic.s_arp_request_valid, ic.s_arp_request_ip, ic.s_arp_response_ready, ic.m_arp_request_ready,
     ic.m_arp_response_valid, ic.m_arp_response_error, ic.m_arp_response_mac} = '0;
    #1;
    chk("rst_busy", a_busy, 0);
    chk("rst_mvalid", ia.m_arp_request_valid, 0);
    chk("rst_mip", ia.m_arp_request_ip, 0);
    chk("rst_grant", a_gnt, 0);
    @(posedge clk); #2;
    rst = 0;
    // Fairness: both ports always valid, downstream always ready; RR instance and FP instance in lockstep.
    ia.s_arp_request_valid = 2'b11;
    ia.s_arp_request_ip = {32'h0A000002, 32'h0A000001};
    ia.m_arp_request_ready = 1;
    ia.m_arp_response_valid = 1;
    ia.s_arp_response_ready = 2'b11;
    ib.s_arp_request_valid = 2'b11;
    ib.s_arp_request_ip = {32'h0A000002, 32'h0A000001};
    ib.m_arp_request_ready = 1;
    ib.m_arp_response_valid = 1;
    ib.s_arp_response_ready = 2'b11;
    n = 0;
    for (int cyc = 0; cyc < 40 && n < 4; cyc++) begin
      @(posedge clk); #2;
      if (ia.m_arp_request_valid) begin
        chk("rr_grant", a_gnt, n % 2);
        chk("rr_ip", ia.m_arp_request_ip, (n % 2) ? 32'h0A000002 : 32'h0A000001);
        chk("fp_valid", ib.m_arp_request_valid, 1);
        chk("fp_grant", b_gnt, 0);
        chk("fp_ip", ib.m_arp_request_ip, 32'h0A000001);
        n++;
      end
    end
    chk("rr_count", n, 4);
    ia.s_arp_request_valid = 0;
    ib.s_arp_request_valid = 0;
    repeat (3) @(posedge clk);
    #2;
    ia.m_arp_request_ready = 0;
    ia.m_arp_response_valid = 0;
    ia.s_arp_response_ready = 0;
    ib.m_arp_request_ready = 0;
    ib.m_arp_response_valid = 0;
    ib.s_arp_response_ready = 0;
    chk("rr_idle", a_busy, 0);
    a_lookup(0, 32'hC0A80102, 48'h5A5152535455, 0, 0, 5, 0);
    a_lookup(1, 32'hC0A80203, 48'h112233445566, 1, 0, 1, 0);
    a_lookup(0, 32'hC0A80304, 48'hA1A2A3A4A5A6, 0, 4, 0, 3);
    // Async reset while a response is being offered.
    ia.s_arp_request_valid = 2'b10;
    ia.s_arp_request_ip[63:32] = 32'h0A0000FF;
    @(posedge clk); #2;
    ia.s_arp_request_valid = 0;
    ia.m_arp_request_ready = 1;
    @(posedge clk); #2;
    ia.m_arp_request_ready = 0;
    ia.m_arp_response_valid = 1;
    ia.s_arp_response_ready = 2'b11;
    #1 chk("pre_rst_ready", ia.m_arp_response_ready, 1);
    #1 rst = 1;
    #1 chk("arst_busy", a_busy, 0);
    chk("arst_rsp_valid", ia.s_arp_response_valid, 0);
    chk("arst_rsp_ready", ia.m_arp_response_ready, 0);
    chk("arst_grant", a_gnt, 0);
    ia.m_arp_response_valid = 0;
    ia.s_arp_response_ready = 0;
    @(posedge clk); #2;
    rst = 0;
    ia.s_arp_request_valid = 2'b11;
    #1 chk("post_rst_accept", ia.s_arp_request_ready, 2'b01);
    @(posedge clk); #2;
    ia.s_arp_request_valid = 0;
    chk("post_rst_grant", a_gnt, 0);
    ia.m_arp_request_ready = 1;
    @(posedge clk); #2;
    ia.m_arp_request_ready = 0;
    ia.m_arp_response_valid = 1;
    ia.s_arp_response_ready = 2'b01;
    @(posedge clk); #2;
    ia.m_arp_response_valid = 0;
    ia.s_arp_response_ready = 0;
    chk("post_rst_idle", a_busy, 0);
    // Four-port wrap: serve port 3, then 0 beats 3, then 2 beats 3.
    c_lookup(4'b1000, 4'b1000);
    chk("c_grant3", c_gnt, 3);
    c_lookup(4'b1001, 4'b0001);
    chk("c_grant0", c_gnt, 0);
    c_lookup(4'b1100, 4'b0100);
    chk("c_grant2", c_gnt, 2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/arp_req_arb.md
Name: arp_req_arb

Overview:
- Shares one ARP lookup interface (ARP cache/requester) between PORTS requesters, e.g. several IP TX engines, each of which issues one request and waits for one response.
- Accepts one request at a time and forwards it downstream.
- Holds the grant until the matching response is handed back, then routes that response to the requester that issued it.
- Arbitration is round-robin or fixed-priority.

Parameters:
- PORTS, 2, number of requesters (1..16).
- ARB_ROUND_ROBIN, 1. 1 = round-robin starting after the last served port; 0 = fixed priority, lowest index wins.
- CL_PORTS, $clog2(PORTS) (minimum 1), width of the grant index; derived, not user-set.

Ports:
- clk  in  1  clock.
- rst  in  1  reset: asynchronous, active-high.
- s_arp_request_valid  in  PORTS  per-requester request valid.
- s_arp_request_ready  out  PORTS  per-requester request accept.
- s_arp_request_ip  in  PORTS*32  per-requester IP address; port i occupies bits [32*i+31:32*i].
- s_arp_response_valid  out  PORTS  per-requester response valid, at most one bit set.
- s_arp_response_ready  in  PORTS  per-requester response ready.
- s_arp_response_error  out  PORTS  error flag; m_arp_response_error broadcast to all bits.
- s_arp_response_mac  out  PORTS*48  MAC; m_arp_response_mac broadcast to all lanes.
- m_arp_request_valid  out  1  downstream request valid.
- m_arp_request_ready  in  1  downstream request ready.
- m_arp_request_ip  out  32  downstream request IP.
- m_arp_response_valid  in  1  downstream response valid.
- m_arp_response_ready  out  1  downstream response ready.
- m_arp_response_error  in  1  downstream response error.
- m_arp_response_mac  in  48  downstream response MAC.
- busy  out  1  high when state is not IDLE.
- grant_index  out  CL_PORTS  port currently or last served.

Behaviour:
- Reset (async, effective immediately, no clock edge needed):
  - state=IDLE; m_arp_request_valid=0; m_arp_request_ip=0; grant_index=0.
  - Last-served pointer = PORTS-1, so port 0 has first priority.
  - All s_arp_request_ready, s_arp_response_valid, m_arp_response_ready = 0; busy=0.
- State IDLE:
  - Winner computed combinationally from s_arp_request_valid.
    - Round-robin: first valid port scanning from pointer+1 upward, wrapping at PORTS-1 to 0.
    - Fixed priority: lowest valid index.
  - s_arp_request_ready = one-hot(winner) when any valid, else 0. The upstream transfer completes this cycle.
  - On transfer, at the next edge: grant_index <= winner; m_arp_request_ip <= s_arp_request_ip[winner]; m_arp_request_valid <= 1; state <= REQ.
  - Request latency: 1 cycle from upstream accept to m_arp_request_valid.
  - Arbitration is re-evaluated every IDLE cycle. A requester deasserting valid before accept loses nothing and is not granted.
- State REQ:
  - m_arp_request_valid held at 1 and m_arp_request_ip held stable until m_arp_request_ready.
  - On handshake: valid <= 0 and state <= RESP.
  - All s_arp_request_ready = 0; m_arp_response_ready = 0.
  - A response presented downstream during REQ is not accepted; it waits for RESP.
- State RESP:
  - s_arp_response_valid[grant_index] = m_arp_response_valid; all other bits 0.
  - m_arp_response_ready = s_arp_response_ready[grant_index]. Both are combinational pass-through, zero added latency.
  - Error and MAC broadcast unmodified.
  - On downstream handshake: pointer <= grant_index; state <= IDLE.
- Throughput:
  - Minimum 3 cycles per lookup (accept, request, response), with a new accept possible in the cycle after the response handshake.
  - No request is issued downstream while a response is outstanding.
- Other upstream ports: all s_arp_request_ready = 0 outside IDLE, so valids held by non-granted ports remain pending.
- PORTS=1: arbitration degenerates to port 0; grant_index is constant 0.
- Reset mid-transaction: the in-flight transaction is abandoned. A downstream response arriving after reset is not accepted until a new request reaches RESP; downstream flushing is the integrator's responsibility.

Test Plan:
1. Basic lookup (PORTS=2, port 0):
   - Stimulus: port 0 requests 0xC0A80102; downstream ready immediately; response mac 0x5A5152535455, error=0 after 5 cycles.
   - Required: s_arp_request_ready[0] pulses once; m_arp_request_ip=0xC0A80102 one cycle later; s_arp_response_valid=2'b01 with the MAC; busy returns low the cycle after the handshake.
2. Round-robin fairness:
   - Stimulus: ports 0 and 1 held valid continuously (IPs 0x0A000001, 0x0A000002), 4 lookups.
   - Required: grant_index sequence 0,1,0,1. Repeat with ARB_ROUND_ROBIN=0 → 0,0,0,0.
3. Error routing:
   - Stimulus: port 1 lookup answered with error=1.
   - Required: s_arp_response_valid=2'b10 and s_arp_response_error[1]=1; port 0 never sees valid.
4. Backpressure:
   - Stimulus: m_arp_request_ready low 4 cycles; later s_arp_response_ready[grant] low 3 cycles.
   - Required: m_arp_request_valid and IP held stable; m_arp_response_ready low for exactly those 3 cycles; no state change until the handshake.
5. Async reset:
   - Stimulus: rst asserted between clock edges while in RESP.
   - Required: busy, s_arp_response_valid and m_arp_response_ready go 0 before the next edge. After release, with ports 0 and 1 valid, port 0 is granted first.
6. Wrap (PORTS=4):
   - Stimulus: last served port 3; ports 0 and 3 valid.
   - Required: port 0 granted. Then with ports 2 and 3 valid, port 2 granted.
